// File: rtl/mem_stage.sv
// EX/MEM latch and data-memory access unit.
// Big-endian byte lanes on a req/ack data bus; stalls while a transaction is open.
module mem_stage #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        flush,
  input  logic [31:0] ex_wdata,
  input  logic [4:0]  ex_waddr,
  input  logic        ex_wr_en,
  input  logic [3:0]  ex_mem_op,
  input  logic [31:0] ex_mem_addr,
  input  logic [31:0] ex_mem_sdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic [31:0] mem_wdata,
  output logic [4:0]  mem_waddr,
  output logic        mem_wr_en,
  output logic        stallreq,
  output logic        addr_err,
  output logic        bus_err
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd8;
  localparam logic [3:0] OP_SH  = 4'd9;
  localparam logic [3:0] OP_SW  = 4'd10;

  localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_LAST);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              flush_pend;
  logic [31:0]       lat_addr;
  logic [31:0]       lat_sdata;
  logic [3:0]        lat_op;
  logic [4:0]        lat_waddr;

  logic        ex_ld;
  logic        ex_st;
  logic        ex_mis;
  logic        lat_ld;
  logic        lat_st;
  logic        acc;
  logic [31:0] ld_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // classify the incoming op and detect misalignment
  always_comb begin
    ex_ld  = (ex_mem_op >= OP_LB) && (ex_mem_op <= OP_LW);
    ex_st  = (ex_mem_op == OP_SB) || (ex_mem_op == OP_SH)
          || (ex_mem_op == OP_SW);
    ex_mis = 1'b0;
    if ((ex_mem_op == OP_LH) || (ex_mem_op == OP_LHU)
        || (ex_mem_op == OP_SH))
      ex_mis = ex_mem_addr[0];
    if ((ex_mem_op == OP_LW) || (ex_mem_op == OP_SW))
      ex_mis = |ex_mem_addr[1:0];
  end

  // bus signals come straight from the latched request while open
  always_comb begin
    acc       = (state == ACCESS);
    lat_ld    = (lat_op >= OP_LB) && (lat_op <= OP_LW);
    lat_st    = (lat_op == OP_SB) || (lat_op == OP_SH)
             || (lat_op == OP_SW);
    stallreq  = acc;
    bus_req   = acc;
    bus_we    = acc && lat_st;
    bus_addr  = 32'h0;
    bus_sel   = 4'b0000;
    bus_wdata = 32'h0;
    if (acc) begin
      bus_addr = {lat_addr[31:2], 2'b00};
      case (lat_op)
        OP_SB: begin
          bus_sel   = 4'b1000 >> lat_addr[1:0];
          bus_wdata = {4{lat_sdata[7:0]}};
        end
        OP_SH: begin
          bus_sel   = lat_addr[1] ? 4'b0011 : 4'b1100;
          bus_wdata = {2{lat_sdata[15:0]}};
        end
        OP_SW: begin
          bus_sel   = 4'b1111;
          bus_wdata = lat_sdata;
        end
        default: bus_sel = 4'b1111;
      endcase
    end
  end

  // pick the addressed lane (offset 0 is the MSB lane) and extend
  always_comb begin
    case (lat_addr[1:0])
      2'd0:    ld_byte = bus_rdata[31:24];
      2'd1:    ld_byte = bus_rdata[23:16];
      2'd2:    ld_byte = bus_rdata[15:8];
      default: ld_byte = bus_rdata[7:0];
    endcase
    ld_half = lat_addr[1] ? bus_rdata[15:0] : bus_rdata[31:16];
    case (lat_op)
      OP_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_data = {24'h0, ld_byte};
      OP_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_data = {16'h0, ld_half};
      default: ld_data = bus_rdata;
    endcase
  end

  // stage state machine, writeback registers and error pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      flush_pend <= 1'b0;
      lat_addr   <= 32'h0;
      lat_sdata  <= 32'h0;
      lat_op     <= 4'h0;
      lat_waddr  <= 5'h0;
      mem_wdata  <= 32'h0;
      mem_waddr  <= 5'h0;
      mem_wr_en  <= 1'b0;
      addr_err   <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      addr_err <= 1'b0;
      bus_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (!stall_in) begin
            if (flush) begin
              mem_wdata <= 32'h0;
              mem_waddr <= 5'h0;
              mem_wr_en <= 1'b0;
            end else if (ex_ld || ex_st) begin
              mem_wr_en <= 1'b0;
              if (ex_mis) begin
                addr_err <= 1'b1;
              end else begin
                lat_addr   <= ex_mem_addr;
                lat_sdata  <= ex_mem_sdata;
                lat_op     <= ex_mem_op;
                lat_waddr  <= ex_waddr;
                cnt        <= '0;
                flush_pend <= 1'b0;
                state      <= ACCESS;
              end
            end else begin
              mem_wdata <= ex_wdata;
              mem_waddr <= ex_waddr;
              mem_wr_en <= ex_wr_en;
            end
          end
        end
        default: begin
          if (flush)
            flush_pend <= 1'b1;
          if (bus_ack) begin
            state      <= IDLE;
            cnt        <= '0;
            flush_pend <= 1'b0;
            if (lat_ld && !flush_pend && !flush) begin
              mem_wdata <= ld_data;
              mem_waddr <= lat_waddr;
              mem_wr_en <= 1'b1;
            end else begin
              mem_wr_en <= 1'b0;
            end
          end else if (TIMEOUT != 0 && cnt == CNT_LAST) begin
            state      <= IDLE;
            cnt        <= '0;
            flush_pend <= 1'b0;
            mem_wr_en  <= 1'b0;
            bus_err    <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage.
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_in;
  logic        flush;
  logic [31:0] ex_wdata;
  logic [4:0]  ex_waddr;
  logic        ex_wr_en;
  logic [3:0]  ex_mem_op;
  logic [31:0] ex_mem_addr;
  logic [31:0] ex_mem_sdata;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic [31:0] mem_wdata;
  logic [4:0]  mem_waddr;
  logic        mem_wr_en;
  logic        stallreq;
  logic        addr_err;
  logic        bus_err;

  int total = 0;
  int bad   = 0;

  mem_stage #(.TIMEOUT(4), .CNT_W(7)) dut (
    .clk(clk), .rst(rst), .stall_in(stall_in), .flush(flush),
    .ex_wdata(ex_wdata), .ex_waddr(ex_waddr), .ex_wr_en(ex_wr_en),
    .ex_mem_op(ex_mem_op), .ex_mem_addr(ex_mem_addr),
    .ex_mem_sdata(ex_mem_sdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_sel(bus_sel), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .mem_wdata(mem_wdata), .mem_waddr(mem_waddr),
    .mem_wr_en(mem_wr_en), .stallreq(stallreq),
    .addr_err(addr_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    ex_wdata     = 32'h0;
    ex_waddr     = 5'h0;
    ex_wr_en     = 1'b0;
    ex_mem_op    = 4'h0;
    ex_mem_addr  = 32'h0;
    ex_mem_sdata = 32'h0;
  endtask

  task automatic put_op(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] sd, input logic [4:0] wa);
    ex_mem_op    = op;
    ex_mem_addr  = a;
    ex_mem_sdata = sd;
    ex_waddr     = wa;
    ex_wr_en     = 1'b1;
    ex_wdata     = a;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall_in = 1'b0; flush = 1'b0;
    bus_ack = 1'b0; bus_rdata = 32'h0;
    clear_ex();
    tick(); tick();
    rst = 1'b0;
    total++;
    if ({bus_req, stallreq, mem_wr_en, addr_err, bus_err} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags got %b want 00000",
               {bus_req, stallreq, mem_wr_en, addr_err, bus_err});
    end
    total++;
    if (mem_wdata !== 32'h0 || mem_waddr !== 5'h0) begin
      bad++;
      $display("FAIL reset_mem got %h/%h want 0/0", mem_wdata, mem_waddr);
    end
  endtask

  task automatic test_nonmem();
    ex_wdata = 32'h1234_5678; ex_waddr = 5'd3; ex_wr_en = 1'b1;
    ex_mem_op = 4'd0;
    tick();
    total++;
    if (mem_wdata !== 32'h1234_5678 || mem_waddr !== 5'd3
        || mem_wr_en !== 1'b1 || bus_req !== 1'b0) begin
      bad++;
      $display("FAIL nonmem got %h %0d %b req=%b want 12345678 3 1 0",
               mem_wdata, mem_waddr, mem_wr_en, bus_req);
    end
    // unknown op codes behave as NONE
    ex_wdata = 32'hCAFE_0001; ex_waddr = 5'd9; ex_mem_op = 4'd7;
    tick();
    total++;
    if (mem_wdata !== 32'hCAFE_0001 || mem_waddr !== 5'd9
        || bus_req !== 1'b0) begin
      bad++;
      $display("FAIL op7_none got %h %0d req=%b want cafe0001 9 0",
               mem_wdata, mem_waddr, bus_req);
    end
    clear_ex();
  endtask

  task automatic test_stall_flush_idle();
    ex_wdata = 32'h0000_00AA; ex_waddr = 5'd4; ex_wr_en = 1'b1;
    tick();
    stall_in = 1'b1; ex_wdata = 32'h0000_00BB; ex_waddr = 5'd6;
    tick();
    stall_in = 1'b0;
    total++;
    if (mem_wdata !== 32'h0000_00AA || mem_waddr !== 5'd4) begin
      bad++;
      $display("FAIL stall_hold got %h %0d want aa 4", mem_wdata, mem_waddr);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    total++;
    if (mem_wdata !== 32'h0 || mem_waddr !== 5'h0
        || mem_wr_en !== 1'b0) begin
      bad++;
      $display("FAIL flush_idle got %h %0d %b want 0 0 0",
               mem_wdata, mem_waddr, mem_wr_en);
    end
    clear_ex();
  endtask

  task automatic test_lb_wait();
    int n;
    put_op(4'd1, 32'h0000_0101, 32'h0, 5'd7);
    tick();
    clear_ex();
    total++;
    if (bus_sel !== 4'b1111 || bus_addr !== 32'h100 || bus_we !== 1'b0) begin
      bad++;
      $display("FAIL lb_bus got sel=%b addr=%h we=%b want 1111 100 0",
               bus_sel, bus_addr, bus_we);
    end
    n = 0;
    while (stallreq === 1'b1 && n < 10) begin
      n++;
      if (n == 3) begin
        bus_ack = 1'b1; bus_rdata = 32'h11F2_3344;
      end
      tick();
      bus_ack = 1'b0;
    end
    total++;
    if (n != 3) begin
      bad++;
      $display("FAIL lb_stall_cycles got %0d want 3", n);
    end
    total++;
    if (mem_wdata !== 32'hFFFF_FFF2 || mem_wr_en !== 1'b1
        || mem_waddr !== 5'd7) begin
      bad++;
      $display("FAIL lb_result got %h %b %0d want fffffff2 1 7",
               mem_wdata, mem_wr_en, mem_waddr);
    end
  endtask

  task automatic test_loads();
    logic [3:0]  ops [5];
    logic [31:0] adr [5];
    logic [31:0] rd  [5];
    logic [31:0] exp [5];
    ops[0] = 4'd3; adr[0] = 32'h102; rd[0] = 32'h1234_8001;
    exp[0] = 32'hFFFF_8001;
    ops[1] = 4'd4; adr[1] = 32'h100; rd[1] = 32'h9ABC_0000;
    exp[1] = 32'h0000_9ABC;
    ops[2] = 4'd2; adr[2] = 32'h103; rd[2] = 32'h0000_00C5;
    exp[2] = 32'h0000_00C5;
    ops[3] = 4'd1; adr[3] = 32'h100; rd[3] = 32'h7F00_0000;
    exp[3] = 32'h0000_007F;
    ops[4] = 4'd5; adr[4] = 32'h104; rd[4] = 32'hDEAD_BEEF;
    exp[4] = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      put_op(ops[i], adr[i], 32'h0, 5'd10 + 5'(i));
      tick();
      clear_ex();
      bus_ack = 1'b1; bus_rdata = rd[i];
      tick();
      bus_ack = 1'b0;
      total++;
      if (mem_wdata !== exp[i] || mem_wr_en !== 1'b1
          || mem_waddr !== 5'd10 + 5'(i)) begin
        bad++;
        $display("FAIL load%0d got %h %b %0d want %h 1 %0d", i,
                 mem_wdata, mem_wr_en, mem_waddr, exp[i], 10 + i);
      end
    end
  endtask

  task automatic test_stores();
    logic [3:0]  ops [3];
    logic [31:0] adr [3];
    logic [31:0] sd  [3];
    logic [3:0]  esel [3];
    logic [31:0] ewd [3];
    logic [31:0] ead [3];
    ops[0] = 4'd9;  adr[0] = 32'h202; sd[0] = 32'h0000_ABCD;
    esel[0] = 4'b0011; ewd[0] = 32'hABCD_ABCD; ead[0] = 32'h200;
    ops[1] = 4'd8;  adr[1] = 32'h201; sd[1] = 32'h1234_565A;
    esel[1] = 4'b0100; ewd[1] = 32'h5A5A_5A5A; ead[1] = 32'h200;
    ops[2] = 4'd10; adr[2] = 32'h30C; sd[2] = 32'h0102_0304;
    esel[2] = 4'b1111; ewd[2] = 32'h0102_0304; ead[2] = 32'h30C;
    for (int i = 0; i < 3; i++) begin
      put_op(ops[i], adr[i], sd[i], 5'd2);
      tick();
      clear_ex();
      total++;
      if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_sel !== esel[i]
          || bus_wdata !== ewd[i] || bus_addr !== ead[i]) begin
        bad++;
        $display("FAIL store%0d got r%b w%b %b %h %h want 1 1 %b %h %h",
                 i, bus_req, bus_we, bus_sel, bus_wdata, bus_addr,
                 esel[i], ewd[i], ead[i]);
      end
      bus_ack = 1'b1;
      tick();
      bus_ack = 1'b0;
      total++;
      if (mem_wr_en !== 1'b0 || bus_req !== 1'b0) begin
        bad++;
        $display("FAIL store%0d_done got wr=%b req=%b want 0 0",
                 i, mem_wr_en, bus_req);
      end
    end
  endtask

  task automatic test_misaligned();
    logic [3:0]  ops [2];
    logic [31:0] adr [2];
    ops[0] = 4'd5; adr[0] = 32'h103;
    ops[1] = 4'd9; adr[1] = 32'h201;
    for (int i = 0; i < 2; i++) begin
      ex_wdata = 32'h55; ex_waddr = 5'd1; ex_wr_en = 1'b1;
      tick();
      put_op(ops[i], adr[i], 32'h0, 5'd8);
      tick();
      clear_ex();
      total++;
      if (addr_err !== 1'b1 || bus_req !== 1'b0 || mem_wr_en !== 1'b0) begin
        bad++;
        $display("FAIL misalign%0d got err=%b req=%b wr=%b want 1 0 0",
                 i, addr_err, bus_req, mem_wr_en);
      end
      tick();
      total++;
      if (addr_err !== 1'b0 || bus_req !== 1'b0) begin
        bad++;
        $display("FAIL misalign%0d_pulse got err=%b req=%b want 0 0",
                 i, addr_err, bus_req);
      end
    end
  endtask

  task automatic test_flush_access();
    put_op(4'd4, 32'h300, 32'h0, 5'd5);
    tick();
    clear_ex();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    total++;
    if (bus_req !== 1'b1) begin
      bad++;
      $display("FAIL flush_req got %b want 1", bus_req);
    end
    bus_ack = 1'b1; bus_rdata = 32'h7777_8888;
    tick();
    bus_ack = 1'b0;
    total++;
    if (bus_req !== 1'b0 || stallreq !== 1'b0 || mem_wr_en !== 1'b0) begin
      bad++;
      $display("FAIL flush_done got req=%b st=%b wr=%b want 0 0 0",
               bus_req, stallreq, mem_wr_en);
    end
  endtask

  task automatic test_stall_in_access();
    put_op(4'd5, 32'h500, 32'h0, 5'd12);
    tick();
    clear_ex();
    stall_in = 1'b1;
    bus_ack = 1'b1; bus_rdata = 32'h0BAD_F00D;
    tick();
    bus_ack = 1'b0;
    stall_in = 1'b0;
    total++;
    if (bus_req !== 1'b0 || mem_wdata !== 32'h0BAD_F00D
        || mem_wr_en !== 1'b1) begin
      bad++;
      $display("FAIL stall_access got req=%b %h %b want 0 0badf00d 1",
               bus_req, mem_wdata, mem_wr_en);
    end
  endtask

  task automatic test_timeout();
    int n;
    put_op(4'd5, 32'h400, 32'h0, 5'd3);
    tick();
    clear_ex();
    n = 0;
    while (bus_req === 1'b1 && n < 10) begin
      n++;
      total++;
      if (bus_err !== 1'b0) begin
        bad++;
        $display("FAIL timeout_early got bus_err=%b at %0d want 0",
                 bus_err, n);
      end
      tick();
    end
    total++;
    if (n != 4) begin
      bad++;
      $display("FAIL timeout_len got %0d want 4", n);
    end
    total++;
    if (bus_err !== 1'b1 || mem_wr_en !== 1'b0) begin
      bad++;
      $display("FAIL timeout_err got err=%b wr=%b want 1 0",
               bus_err, mem_wr_en);
    end
    put_op(4'd10, 32'h410, 32'h99, 5'd0);
    tick();
    clear_ex();
    total++;
    if (bus_err !== 1'b0 || bus_req !== 1'b1 || bus_addr !== 32'h410) begin
      bad++;
      $display("FAIL timeout_next got err=%b req=%b %h want 0 1 410",
               bus_err, bus_req, bus_addr);
    end
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    put_op(4'd5, 32'h600, 32'h0, 5'd3);
    tick();
    clear_ex();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (bus_req !== 1'b0 || bus_err !== 1'b0 || stallreq !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid got req=%b err=%b st=%b want 0 0 0",
               bus_req, bus_err, stallreq);
    end
    tick();
    total++;
    if (bus_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_err got %b want 0", bus_err);
    end
  endtask

  initial begin
    test_reset();
    test_nonmem();
    test_stall_flush_idle();
    test_lb_wait();
    test_loads();
    test_stores();
    test_misaligned();
    test_flush_access();
    test_stall_in_access();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
